turn_timer_1hz: RTL and testbench
=================================

Name: turn_timer_1hz

Overview:
- Player-turn countdown for the BlackJack table. Sits directly downstream of the 1 Hz divider and consumes its 50%-duty 1 Hz square wave.
- Counts down a decision window in whole seconds and drives two BCD digits to the 7-segment driver.
- Raises a warning near the end and a timeout event that the game FSM uses to force "stand".

Parameters:
INIT_SEC, 30, reload value in seconds; legal range 1..99.
WARN_SEC, 5, warn asserts when remaining seconds are between 1 and WARN_SEC inclusive; legal range 0..INIT_SEC.

Ports:
clk  input  1  system clock; the same clock that feeds the 1 Hz divider.
rst  input  1  asynchronous, active-high reset.
tick_in  input  1  1 Hz level from the divider, synchronous to clk.
start  input  1  1-cycle pulse: load INIT_SEC and run.
pause_tgl  input  1  1-cycle pulse: toggle between RUN and PAUSE.
clear  input  1  1-cycle pulse: abort and return to IDLE.
sec_tens  output  4  BCD tens digit of remaining seconds.
sec_ones  output  4  BCD ones digit of remaining seconds.
running  output  1  high in RUN.
paused  output  1  high in PAUSE.
warn  output  1  low-time warning level.
timeout  output  1  1-cycle pulse when the count reaches 0.
expired  output  1  level, high in EXPIRED.

Behaviour:
- Reset (async, rst=1):
  - State is IDLE.
  - Digits are loaded with INIT_SEC (30 gives tens=3, ones=0).
  - tick_prev=0.
  - running, paused, warn, timeout and expired are all 0.
  - Reset takes effect immediately, without waiting for a clk edge, including mid-run.
- Edge detect:
  - tick_prev is registered from tick_in every cycle.
  - tick_rise = tick_in & ~tick_prev.
  - One decrement per rising edge, however long tick_in stays high.
- States and transitions, evaluated in priority order clear > start > pause_tgl > tick_rise:
  - clear in any state: go to IDLE and reload INIT_SEC.
  - start in any state: reload INIT_SEC and go to RUN. This restarts the count from RUN, PAUSE or EXPIRED.
  - pause_tgl in RUN: go to PAUSE.
  - pause_tgl in PAUSE: go to RUN.
  - pause_tgl is ignored in IDLE and EXPIRED.
  - tick_rise in RUN with count > 1: decrement the count by 1.
  - tick_rise in RUN with count == 1: count becomes 0, go to EXPIRED, and assert timeout for exactly that one cycle.
  - tick_rise is ignored in IDLE, PAUSE and EXPIRED.
- Simultaneous events: a tick in the same cycle as clear, start or pause_tgl is dropped, not deferred.
- Arithmetic:
  - The count is held directly as two BCD digits; there is no binary counter.
  - Decrement: if ones==0, then ones becomes 9 and tens decrements; otherwise ones decrements.
  - The count never goes below 0.
- Latency:
  - The count and state update on the clk edge that first samples tick_in=1.
  - The new digits are visible immediately after that edge.
  - timeout is registered and high during the cycle following that edge.
- Output decode:
  - running, paused and expired are decoded from the state register.
  - warn = (RUN or PAUSE) and count != 0 and count <= WARN_SEC. The comparison is on the BCD value; no extra latency.
- Hold behaviour:
  - EXPIRED holds 0,0 until start or clear.
  - In IDLE the digits hold INIT_SEC.

Decomposition:
- Shared package blackjack_pkg contains:
  - the state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, EXPIRED=2'd3;
  - the BCD digit width, 4;
  - the default turn-time constants.
- One sub-module, bcd_down2: a two-digit BCD down-counter with load (value), dec (enable), and zero/one flags.
- The top level contains the edge detect, the state machine, the warn compare and the timeout register.

Test Plan:
- Reset: assert rst mid-cycle -> outputs go immediately to tens=3, ones=0 with running, paused, warn, timeout and expired all 0. Deassert rst, then hold tick_in=1 for 10 cycles -> no count change in IDLE.
- Counting: start, then 3 tick_in rising edges, each held high for 5 cycles -> digits 2,7 and running=1. The ones wrap is correct: 30 decrements to 29.
- Expiry: start, then 30 rising edges:
  - warn is 1 while the count is 5..1;
  - after the 30th edge the digits are 0,0 and warn=0;
  - timeout is high for exactly 1 cycle, expired=1 and running=0;
  - 3 further ticks cause no change.
- Pause: pause_tgl at count 25 -> paused=1 and 10 ticks cause no change. A second pause_tgl followed by a tick -> 24 and running=1.
- Collisions:
  - start in the same cycle as tick_rise at count 12 -> 30, not 29;
  - pause_tgl in the same cycle as a tick at count 20 -> PAUSE with 20 held;
  - clear during PAUSE -> IDLE with 30 loaded.
- Reset mid-run: rst pulse at count 7 during RUN -> IDLE with 30 loaded, before the next clk edge; the next tick is ignored.

Source files
------------

// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared constants for the BlackJack table turn timer
//
// Purpose: state encoding, BCD digit width and default turn-time constants
//          shared by turn_timer_1hz and its BCD counter.
// Ports:   none (package).
package blackjack_pkg;

   // BCD digit width driven to the 7-segment driver
   localparam int DIGIT_W = 4;

   // Turn-timer state encoding (kept as plain constants for legacy users)
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_PAUSE   = 2'd2;
   localparam logic [1:0] ST_EXPIRED = 2'd3;

   // Default turn-time constants, in whole seconds
   localparam int DEFAULT_INIT_SEC = 30;
   localparam int DEFAULT_WARN_SEC = 5;

   // Packs a 0..99 seconds value into {tens, ones} BCD at elaboration time
   function automatic logic [2*DIGIT_W-1:0] sec_to_bcd(input int sec);
      logic [DIGIT_W-1:0] t;
      logic [DIGIT_W-1:0] o;
      t = DIGIT_W'(sec / 10);
      o = DIGIT_W'(sec % 10);
      return {t, o};
   endfunction

endpackage

// File: rtl/bcd_down2.sv
// rtl/bcd_down2.sv - two-digit BCD down-counter with load and zero/one flags
//
// Purpose: holds a 00..99 count as two BCD digits; load has priority over
//          dec, and dec saturates at 00.
// Ports:
//   clk, rst            clock, async active-high reset (loads RST_VALUE)
//   load                load value_tens/value_ones this edge
//   value_tens/ones     BCD value to load
//   dec                 decrement by one this edge (ignored at 00)
//   tens, ones          current BCD digits
//   zero, one           count == 00 / count == 01
module bcd_down2
   import blackjack_pkg::*;
#(
   parameter logic [2*DIGIT_W-1:0] RST_VALUE = 8'h30
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic [DIGIT_W-1:0] value_tens,
   input  logic [DIGIT_W-1:0] value_ones,
   input  logic               dec,
   output logic [DIGIT_W-1:0] tens,
   output logic [DIGIT_W-1:0] ones,
   output logic               zero,
   output logic               one
);

   assign zero = (tens == '0) && (ones == '0);
   assign one  = (tens == '0) && (ones == DIGIT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens <= RST_VALUE[2*DIGIT_W-1:DIGIT_W];
         ones <= RST_VALUE[DIGIT_W-1:0];
      end else if (load) begin
         tens <= value_tens;
         ones <= value_ones;
      end else if (dec && !zero) begin
         // borrow from tens when the ones digit wraps 0 -> 9
         if (ones == '0) begin
            ones <= DIGIT_W'(9);
            tens <= tens - DIGIT_W'(1);
         end else begin
            ones <= ones - DIGIT_W'(1);
         end
      end
   end

endmodule

// File: rtl/turn_timer_1hz.sv
// rtl/turn_timer_1hz.sv - player-turn countdown driven by the 1 Hz divider
//
// Purpose: counts a decision window down in whole seconds as two BCD digits,
//          raises warn near the end and a one-cycle timeout at zero.
// Ports:
//   clk, rst            system clock, async active-high reset
//   tick_in             1 Hz level from the divider (synchronous to clk)
//   start               pulse: reload INIT_SEC and run
//   pause_tgl           pulse: toggle RUN <-> PAUSE
//   clear               pulse: abort to IDLE with INIT_SEC loaded
//   sec_tens, sec_ones  BCD remaining seconds
//   running, paused     state decodes for RUN / PAUSE
//   warn                remaining in 1..WARN_SEC while RUN or PAUSE
//   timeout             one-cycle pulse after the count reaches 0
//   expired             high in EXPIRED
module turn_timer_1hz
   import blackjack_pkg::*;
#(
   parameter int INIT_SEC = DEFAULT_INIT_SEC,
   parameter int WARN_SEC = DEFAULT_WARN_SEC
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick_in,
   input  logic                start,
   input  logic                pause_tgl,
   input  logic                clear,
   output logic [DIGIT_W-1:0]  sec_tens,
   output logic [DIGIT_W-1:0]  sec_ones,
   output logic                running,
   output logic                paused,
   output logic                warn,
   output logic                timeout,
   output logic                expired
);

   localparam logic [2*DIGIT_W-1:0] INIT_BCD = sec_to_bcd(INIT_SEC);
   localparam logic [2*DIGIT_W-1:0] WARN_BCD = sec_to_bcd(WARN_SEC);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       tick_prev;
   logic       tick_rise;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;
   logic       cnt_one;
   logic       timeout_nxt;

   assign tick_rise = tick_in & ~tick_prev;

   bcd_down2 #(
      .RST_VALUE (INIT_BCD)
   ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .value_tens (INIT_BCD[2*DIGIT_W-1:DIGIT_W]),
      .value_ones (INIT_BCD[DIGIT_W-1:0]),
      .dec        (cnt_dec),
      .tens       (sec_tens),
      .ones       (sec_ones),
      .zero       (cnt_zero),
      .one        (cnt_one)
   );

   // Events are mutually exclusive per cycle: a tick that coincides with
   // clear/start/pause_tgl is dropped rather than deferred.
   always_comb begin
      state_nxt   = state;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      timeout_nxt = 1'b0;
      if (clear) begin
         state_nxt = ST_IDLE;
         cnt_load  = 1'b1;
      end else if (start) begin
         state_nxt = ST_RUN;
         cnt_load  = 1'b1;
      end else if (pause_tgl) begin
         if (state == ST_RUN) begin
            state_nxt = ST_PAUSE;
         end else if (state == ST_PAUSE) begin
            state_nxt = ST_RUN;
         end
      end else if (tick_rise && (state == ST_RUN)) begin
         cnt_dec = 1'b1;
         if (cnt_one) begin
            state_nxt   = ST_EXPIRED;
            timeout_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         tick_prev <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nxt;
         tick_prev <= tick_in;
         timeout   <= timeout_nxt;
      end
   end

   assign running = (state == ST_RUN);
   assign paused  = (state == ST_PAUSE);
   assign expired = (state == ST_EXPIRED);

   // For valid BCD, comparing the packed {tens,ones} byte orders the same
   // as comparing the decimal values.
   assign warn = (running || paused) && !cnt_zero
                 && ({sec_tens, sec_ones} <= WARN_BCD);

endmodule

// File: tb/tb_turn_timer_1hz.sv
// tb/tb_turn_timer_1hz.sv - directed self-checking bench for turn_timer_1hz
module tb_turn_timer_1hz;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick_in = 1'b0;
   logic       start = 1'b0;
   logic       pause_tgl = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       running;
   logic       paused;
   logic       warn;
   logic       timeout;
   logic       expired;

   int checks = 0;
   int failures = 0;
   int to_cnt = 0;

   turn_timer_1hz dut (
      .clk       (clk),
      .rst       (rst),
      .tick_in   (tick_in),
      .start     (start),
      .pause_tgl (pause_tgl),
      .clear     (clear),
      .sec_tens  (sec_tens),
      .sec_ones  (sec_ones),
      .running   (running),
      .paused    (paused),
      .warn      (warn),
      .timeout   (timeout),
      .expired   (expired)
   );

   always #5 clk = ~clk;

   // timeout cycles observed mid-cycle, away from the active edge
   always @(negedge clk) if (timeout === 1'b1) to_cnt++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_edge(input int hold);
      tick_in = 1'b1;
      step(hold);
      tick_in = 1'b0;
      step(2);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick_edge(1);
   endtask

   task automatic pulse_start();
      start = 1'b1; step(1); start = 1'b0;
   endtask

   task automatic pulse_pause();
      pause_tgl = 1'b1; step(1); pause_tgl = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1; step(1); clear = 1'b0;
   endtask

   function automatic logic [7:0] bcd(input int v);
      logic [3:0] t;
      logic [3:0] o;
      t = 4'(v / 10);
      o = 4'(v % 10);
      return {t, o};
   endfunction

   task automatic check_count(input string tag, input int v);
      check(tag, {24'd0, sec_tens, sec_ones}, {24'd0, bcd(v)});
   endtask

   initial begin
      // reset asserted mid-cycle, checked before any clock edge
      #2 rst = 1'b1;
      #1;
      check_count("reset_digits", 30);
      check("reset_flags", {27'd0, running, paused, warn, timeout, expired}, 32'd0);
      step(2);
      rst = 1'b0;
      step(1);

      // ticks in IDLE are ignored
      tick_in = 1'b1; step(10); tick_in = 1'b0; step(2);
      check_count("idle_tick_hold", 30);
      check("idle_running", running, 1'b0);

      // counting with long-held tick levels: one decrement per edge
      pulse_start();
      check("start_running", running, 1'b1);
      check_count("start_digits", 30);
      tick_edge(5);
      check_count("wrap_30_to_29", 29);
      tick_edge(5);
      tick_edge(5);
      check_count("count_27", 27);
      check("count_running", running, 1'b1);

      // full expiry with warn window tracked on every second
      pulse_start();
      to_cnt = 0;
      for (int k = 1; k <= 30; k++) begin
         tick_edge(1);
         check_count($sformatf("exp_digits_%0d", 30 - k), 30 - k);
         check($sformatf("exp_warn_%0d", 30 - k), warn,
               ((30 - k) >= 1 && (30 - k) <= 5) ? 1'b1 : 1'b0);
      end
      check("timeout_pulses", to_cnt, 1);
      check("expired_level", expired, 1'b1);
      check("expired_running", running, 1'b0);
      ticks(3);
      check_count("expired_hold", 0);
      check("expired_still", expired, 1'b1);
      check("timeout_once", to_cnt, 1);

      // pause / resume
      pulse_start();
      ticks(5);
      check_count("pause_at_25", 25);
      pulse_pause();
      check("paused_level", paused, 1'b1);
      check("paused_running", running, 1'b0);
      ticks(10);
      check_count("pause_hold", 25);
      pulse_pause();
      check("resume_running", running, 1'b1);
      tick_edge(1);
      check_count("resume_24", 24);

      // start colliding with a tick at 12
      pulse_start();
      ticks(18);
      check_count("coll_at_12", 12);
      tick_in = 1'b1; start = 1'b1; step(1); start = 1'b0; tick_in = 1'b0; step(2);
      check_count("coll_start_30", 30);
      check("coll_start_run", running, 1'b1);

      // pause_tgl colliding with a tick at 20
      ticks(10);
      check_count("coll_at_20", 20);
      tick_in = 1'b1; pause_tgl = 1'b1; step(1); pause_tgl = 1'b0; tick_in = 1'b0; step(2);
      check("coll_pause_paused", paused, 1'b1);
      check_count("coll_pause_20", 20);

      // clear during PAUSE
      pulse_clear();
      check("clear_paused", paused, 1'b0);
      check("clear_running", running, 1'b0);
      check_count("clear_30", 30);

      // asynchronous reset mid-run, observed before the next edge
      pulse_start();
      ticks(23);
      check_count("mid_at_7", 7);
      #2 rst = 1'b1;
      #1;
      check_count("async_rst_digits", 30);
      check("async_rst_running", running, 1'b0);
      step(1);
      rst = 1'b0;
      step(1);
      tick_edge(1);
      check_count("post_rst_tick", 30);
      check("post_rst_idle", {30'd0, running, expired}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
